// File: rtl/int4_mac_seq.sv
// int4_mac_seq: sequences a K-block dot-product job through one combinational int4_mac instance.
// Optional build macro INT4_MAC_SAT_EN: saturate the accumulator at 24'hFFFFFF and expose res_sat.
module int4_mac_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_blocks,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [263:0]     in_a_vec,
    input  logic [263:0]     in_b_vec,
    output logic             mac_en,
    output logic [263:0]     mac_a_vec,
    output logic [263:0]     mac_b_vec,
    output logic [23:0]      mac_psum_in,
    input  logic [23:0]      mac_psum_out,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [23:0]      res_sum,
    output logic [7:0]       res_scale
`ifdef INT4_MAC_SAT_EN
    ,
    output logic             res_sat
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [23:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] nb_q;
    logic [7:0]       scale_q;
    logic             sat_q, sat_d;
    logic             beat;
    logic             last_beat;
    logic             job_start;

    assign beat      = (state_q == ST_ACCUM) && in_valid;
    assign last_beat = (cnt_q == nb_q - CNT_W'(1));
    assign job_start = (state_q == ST_IDLE) && start;

    // Operands always pass through; only the MAC result is qualified by mac_en.
    assign mac_a_vec   = in_a_vec;
    assign mac_b_vec   = in_b_vec;
    assign mac_psum_in = acc_q;

`ifdef INT4_MAC_SAT_EN
    // Contributions are non-negative and under 2^14, so a smaller result means a carry out of bit 23.
    always_comb begin
        acc_d = mac_psum_out;
        sat_d = sat_q;
        if (mac_psum_out < acc_q) begin
            acc_d = 24'hFF_FFFF;
            sat_d = 1'b1;
        end
    end

    assign res_sat = (state_q == ST_DONE) && sat_q;
`else
    always_comb begin
        acc_d = mac_psum_out;
        sat_d = 1'b0;
    end
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        mac_en    = 1'b0;
        busy      = 1'b1;
        res_valid = 1'b0;
        res_sum   = 24'd0;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = (num_blocks == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                mac_en   = in_valid;
                if (beat && last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                res_valid = 1'b1;
                res_sum   = acc_q;
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    assign res_scale = scale_q;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every datapath register is reset; none of them is a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= 24'd0;
            cnt_q   <= '0;
            nb_q    <= '0;
            scale_q <= 8'd0;
            sat_q   <= 1'b0;
        end else if (abort) begin
            acc_q <= 24'd0;
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (job_start) begin
            acc_q   <= 24'd0;
            cnt_q   <= '0;
            nb_q    <= num_blocks;
            scale_q <= 8'd0;
            sat_q   <= 1'b0;
        end else if (beat) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            sat_q <= sat_d;
            if (cnt_q == '0) begin
                scale_q <= in_a_vec[7:0];
            end
        end
    end

endmodule

// File: tb/tb_int4_mac_seq.sv
// Self-checking bench for int4_mac_seq: directed scenarios plus randomized jobs against a sum-of-products model.
module tb_int4_mac_seq;

    localparam int CNT_W = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic             res_ready = 1'b0;
    logic [CNT_W-1:0] num_blocks = '0;
    logic [263:0]     in_a_vec = '0;
    logic [263:0]     in_b_vec = '0;
    logic             in_ready, mac_en, busy, res_valid;
    logic [263:0]     mac_a_vec, mac_b_vec;
    logic [23:0]      mac_psum_in, mac_psum_out, res_sum;
    logic [7:0]       res_scale;
`ifdef INT4_MAC_SAT_EN
    logic             res_sat;
`endif

    int checks = 0;
    int errors = 0;
    logic [263:0] a_q[$];
    logic [263:0] b_q[$];

    int4_mac_seq #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_blocks(num_blocks), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_a_vec(in_a_vec), .in_b_vec(in_b_vec),
        .mac_en(mac_en), .mac_a_vec(mac_a_vec), .mac_b_vec(mac_b_vec),
        .mac_psum_in(mac_psum_in), .mac_psum_out(mac_psum_out),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_scale(res_scale)
`ifdef INT4_MAC_SAT_EN
        , .res_sat(res_sat)
`endif
    );

    always #5 clk = ~clk;

    // Unsigned dot product of data nibbles 2..64; scale nibbles and the top nibble do not contribute.
    function automatic int dot(input logic [263:0] a, input logic [263:0] b);
        int s = 0;
        for (int i = 2; i <= 64; i++) s += int'(a[4*i +: 4]) * int'(b[4*i +: 4]);
        return s;
    endfunction

    // Stand-in for the combinational int4_mac.
    always_comb mac_psum_out = mac_en ? mac_psum_in + 24'(dot(mac_a_vec, mac_b_vec)) : 24'd0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [263:0] const_vec(input logic [3:0] nib, input logic [7:0] scale);
        logic [263:0] v;
        for (int i = 0; i < 66; i++) v[4*i +: 4] = nib;
        v[7:0] = scale;
        return v;
    endfunction

    function automatic logic [263:0] rand_vec();
        logic [263:0] v;
        for (int i = 0; i < 66; i++) v[4*i +: 4] = 4'($urandom);
        return v;
    endfunction

    task automatic fill_const(input int nb, input logic [3:0] an, input logic [7:0] asc, input logic [3:0] bn);
        a_q.delete();
        b_q.delete();
        for (int i = 0; i < nb; i++) begin
            a_q.push_back(const_vec(an, asc));
            b_q.push_back(const_vec(bn, {bn, bn}));
        end
    endtask

    task automatic fill_rand(input int nb);
        a_q.delete();
        b_q.delete();
        for (int i = 0; i < nb; i++) begin
            a_q.push_back(rand_vec());
            b_q.push_back(rand_vec());
        end
    endtask

    // Runs one job from a_q/b_q and checks the result against the model.
    task automatic run_job(input int nb, input int gap_pct, input bit alt, input int hold,
                           input bit poke, input string tag);
        longint      total = 0;
        logic [23:0] exp_sum;
        logic [7:0]  exp_scale;
        bit          exp_sat;
        int          idx = 0, cyc = 0, bad_ready = 0, bad_mac = 0, bad_hold = 0;
        bit          v;
        for (int i = 0; i < nb; i++) total += longint'(dot(a_q[i], b_q[i]));
`ifdef INT4_MAC_SAT_EN
        exp_sat = (total > 64'hFF_FFFF);
        exp_sum = exp_sat ? 24'hFF_FFFF : 24'(total);
`else
        exp_sat = 1'b0;
        exp_sum = 24'(total);
`endif
        exp_scale = (nb > 0) ? a_q[0][7:0] : 8'd0;

        start = 1'b1;
        num_blocks = CNT_W'(nb);
        step();
        start = 1'b0;
        while (idx < nb && cyc < nb * 20 + 50) begin
            v = alt ? (cyc % 2 == 0) : ($urandom_range(99) >= gap_pct);
            in_valid = v;
            in_a_vec = a_q[idx];
            in_b_vec = b_q[idx];
            if (poke && idx == nb / 2) begin
                start = 1'b1;
                num_blocks = CNT_W'($urandom);
            end
            #1;
            if (in_ready !== 1'b1) bad_ready++;
            if (mac_en !== v || mac_a_vec !== in_a_vec || mac_b_vec !== in_b_vec) bad_mac++;
            step();
            start = 1'b0;
            if (v) idx++;
            cyc++;
        end
        in_valid = 1'b0;

        checks++;
        if (idx < nb) begin
            errors++;
            $display("FAIL %s timeout: accepted %0d of %0d blocks", tag, idx, nb);
            abort = 1'b1;
            step();
            abort = 1'b0;
            return;
        end
        if (nb > 0) begin
            checks++;
            if (bad_ready != 0) begin
                errors++;
                $display("FAIL %s in_ready: low on %0d accumulate cycles, expected 0", tag, bad_ready);
            end
            checks++;
            if (bad_mac != 0) begin
                errors++;
                $display("FAIL %s mac_drive: %0d cycles with wrong mac_en/operands, expected 0", tag, bad_mac);
            end
        end
        checks++;
        if (res_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || mac_en !== 1'b0) begin
            errors++;
            $display("FAIL %s done_ctrl: valid=%b busy=%b ready=%b mac_en=%b, expected 1 1 0 0",
                     tag, res_valid, busy, in_ready, mac_en);
        end
        checks++;
        if (res_sum !== exp_sum) begin
            errors++;
            $display("FAIL %s res_sum: got %0d expected %0d", tag, res_sum, exp_sum);
        end
        checks++;
        if (res_scale !== exp_scale) begin
            errors++;
            $display("FAIL %s res_scale: got %h expected %h", tag, res_scale, exp_scale);
        end
`ifdef INT4_MAC_SAT_EN
        checks++;
        if (res_sat !== exp_sat) begin
            errors++;
            $display("FAIL %s res_sat: got %b expected %b", tag, res_sat, exp_sat);
        end
`endif

        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            if (poke) begin
                start = 1'b1;
                num_blocks = CNT_W'($urandom);
            end
            step();
            start = 1'b0;
            if (res_valid !== 1'b1 || res_sum !== exp_sum || res_scale !== exp_scale) bad_hold++;
        end
        if (hold > 0) begin
            checks++;
            if (bad_hold != 0) begin
                errors++;
                $display("FAIL %s hold: result changed on %0d of %0d stalled cycles, expected 0",
                         tag, bad_hold, hold);
            end
        end

        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s handshake: busy=%b valid=%b, expected 0 0", tag, busy, res_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({in_ready, busy, res_valid, mac_en} !== 4'b0000) begin
            errors++;
            $display("FAIL reset ctrl: ready/busy/valid/mac_en=%b expected 0000",
                     {in_ready, busy, res_valid, mac_en});
        end
        checks++;
        if (res_sum !== 24'd0 || res_scale !== 8'd0) begin
            errors++;
            $display("FAIL reset data: sum=%0d scale=%h expected 0 00", res_sum, res_scale);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_ones();
        fill_const(4, 4'h1, 8'h11, 4'h1);
        run_job(4, 0, 1'b0, 0, 1'b0, "ones");
    endtask

    task automatic test_toggle_hold();
        fill_const(2, 4'hF, 8'h53, 4'hF);
        run_job(2, 0, 1'b1, 3, 1'b0, "toggle");
    endtask

    task automatic test_zero_blocks();
        a_q.delete();
        b_q.delete();
        run_job(0, 0, 1'b0, 1, 1'b0, "zero");
    endtask

    task automatic test_abort();
        int bad_valid = 0;
        fill_const(4, 4'h1, 8'h11, 4'h1);
        start = 1'b1;
        num_blocks = CNT_W'(4);
        step();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_a_vec = a_q[i];
            in_b_vec = b_q[i];
            step();
        end
        in_a_vec = a_q[2];
        in_b_vec = b_q[2];
        abort = 1'b1;
        step();
        abort = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort idle: busy=%b ready=%b valid=%b expected 0 0 0", busy, in_ready, res_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (res_valid !== 1'b0) bad_valid++;
        end
        checks++;
        if (bad_valid != 0) begin
            errors++;
            $display("FAIL abort no_result: res_valid high %0d cycles expected 0", bad_valid);
        end
        fill_const(1, 4'h1, 8'h11, 4'h1);
        run_job(1, 0, 1'b0, 0, 1'b0, "after_abort");
    endtask

    task automatic test_start_ignored();
        fill_rand(9);
        run_job(9, 25, 1'b0, 2, 1'b1, "start_ignored");
    endtask

    task automatic test_random();
        for (int j = 0; j < 8; j++) begin
            int nb = $urandom_range(20, 1);
            fill_rand(nb);
            run_job(nb, 30, 1'b0, $urandom_range(3, 0), 1'b0, "random");
        end
    endtask

    task automatic test_long_wrap();
        fill_const(1200, 4'hF, 8'h53, 4'hF);
        run_job(1200, 0, 1'b0, 0, 1'b0, "long1200");
    endtask

    task automatic test_reset_mid_job();
        fill_rand(5);
        start = 1'b1;
        num_blocks = CNT_W'(5);
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_a_vec = a_q[0];
        in_b_vec = b_q[0];
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, busy, res_valid, mac_en} !== 4'b0000 || res_sum !== 24'd0 || res_scale !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: ctrl=%b sum=%0d scale=%h expected 0000 0 00",
                     {in_ready, busy, res_valid, mac_en}, res_sum, res_scale);
        end
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset idle: busy=%b valid=%b expected 0 0", busy, res_valid);
        end
        fill_const(1, 4'h1, 8'h11, 4'h1);
        run_job(1, 0, 1'b0, 0, 1'b0, "after_reset");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ones();
        test_toggle_hold();
        test_zero_blocks();
        test_abort();
        test_start_ignored();
        test_random();
        test_long_wrap();
        test_reset_mid_job();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
